decode_writeback: RTL and testbench

- Y86-64 SEQ decode/writeback stage: the 15-entry register file that supplies val_a and val_b to execute, and retires val_e and val_m into the register file.
- Decode is combinational from the current register contents.
- Writeback commits on the rising clock edge at the end of the same instruction cycle.
- A halt latch stops register updates after a halt instruction retires.

---
 rtl/decode_writeback.sv | 102 ++++++++++
 tb/tb_decode_writeback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 SEQ register file providing decode operands, writeback commit and a sticky halt latch.
// Optional build macro REGFILE_BYPASS_EN forwards the current cycle's writeback data onto val_a/val_b/dbg_val.
module decode_writeback #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       in_code,
  input  logic [3:0]       in_fun,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [WIDTH-1:0] val_e,
  input  logic [WIDTH-1:0] val_m,
  input  logic             cnd,
  output logic [WIDTH-1:0] val_a,
  output logic [WIDTH-1:0] val_b,
  output logic             halted,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_val
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  icode_e           icode;
  logic [3:0]       src_a, src_b, dst_e, dst_m;
  logic             we_e, we_m;
  logic [WIDTH-1:0] regs    [15];
  logic [WIDTH-1:0] rf_view [16];
  logic             unused_fun;

  // ifun only qualifies cmovXX upstream via cnd; it plays no part here.
  assign unused_fun = ^in_fun;
  assign icode      = icode_e'(in_code);

  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;
    case (icode)
      I_RRMOVQ: begin src_a = ra;    dst_e = cnd ? rb : R_NONE;                end
      I_IRMOVQ: begin dst_e = rb;                                               end
      I_RMMOVQ: begin src_a = ra;    src_b = rb;                                end
      I_MRMOVQ: begin src_b = rb;    dst_m = ra;                                end
      I_OPQ:    begin src_a = ra;    src_b = rb;    dst_e = rb;                 end
      I_CALL:   begin src_b = R_RSP; dst_e = R_RSP;                             end
      I_RET:    begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP;              end
      I_PUSHQ:  begin src_a = ra;    src_b = R_RSP; dst_e = R_RSP;              end
      I_POPQ:   begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; dst_m = ra;  end
      default:  ;
    endcase
  end

  assign we_e = !halted && (dst_e != R_NONE);
  assign we_m = !halted && (dst_m != R_NONE);

  // Slot 15 reads as zero so "none" needs no special case on the read ports.
  always_comb begin
    for (int unsigned i = 0; i < 15; i++) rf_view[i] = regs[i];
    rf_view[15] = '0;
`ifdef REGFILE_BYPASS_EN
    if (we_e) rf_view[dst_e] = val_e;
    if (we_m) rf_view[dst_m] = val_m;
`endif
  end

  assign val_a   = rf_view[src_a];
  assign val_b   = rf_view[src_b];
  assign dbg_val = rf_view[dbg_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted <= 1'b0;
      for (int unsigned i = 0; i < 15; i++) regs[i] <= (i == 4) ? RSP_INIT : '0;
    end else if (!halted) begin
      if (icode == I_HALT) halted <= 1'b1;
      // M port checked first so popq %rsp keeps the loaded value.
      for (int unsigned i = 0; i < 15; i++) begin
        if (we_m && dst_m == 4'(i))      regs[i] <= val_m;
        else if (we_e && dst_e == 4'(i)) regs[i] <= val_e;
      end
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: randomized and directed checks of decode_writeback against a spec-level register model.
// Honors REGFILE_BYPASS_EN the same way as the design build.
module tb_decode_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  in_code, in_fun, ra, rb, dbg_sel;
  logic [63:0] val_e, val_m;
  logic        cnd;
  logic [63:0] val_a, val_b, dbg_val;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [63:0] mregs [15];
  logic        mhalt;

  decode_writeback #(.WIDTH(64), .RSP_INIT(64'h100)) dut (
    .clock(clock), .reset_n(reset_n), .in_code(in_code), .in_fun(in_fun),
    .ra(ra), .rb(rb), .val_e(val_e), .val_m(val_m), .cnd(cnd),
    .val_a(val_a), .val_b(val_b), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] m_src_a(input logic [3:0] c, input logic [3:0] a);
    case (c)
      4'h2, 4'h4, 4'h6, 4'hA: return a;
      4'h9, 4'hB:             return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] c, input logic [3:0] b);
    case (c)
      4'h4, 4'h5, 4'h6:       return b;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] c, input logic [3:0] b, input logic f);
    case (c)
      4'h2:                   return f ? b : 4'hF;
      4'h3, 4'h6:             return b;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] c, input logic [3:0] a);
    return (c == 4'h5 || c == 4'hB) ? a : 4'hF;
  endfunction

  // Expected read of register idx given current model state and current inputs.
  function automatic logic [63:0] exp_read(input logic [3:0] idx);
    logic [63:0] v;
    if (idx == 4'hF) return 64'd0;
    v = mregs[idx];
`ifdef REGFILE_BYPASS_EN
    if (!mhalt) begin
      if (m_dst_e(in_code, rb, cnd) == idx) v = val_e;
      if (m_dst_m(in_code, ra) == idx)      v = val_m;
    end
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
    mregs[4] = 64'h100;
    mhalt = 1'b0;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] ve, input logic [63:0] vm, input logic f);
    in_code = c; in_fun = 4'($urandom_range(0, 15)); ra = a; rb = b;
    val_e = ve; val_m = vm; cnd = f;
  endtask

  // Clock edge: commit the model per architectural rules, then park on a nop.
  task automatic tick();
    logic [3:0] de, dm;
    @(posedge clock);
    if (reset_n && !mhalt) begin
      if (in_code == 4'h0) mhalt = 1'b1;
      else begin
        de = m_dst_e(in_code, rb, cnd);
        dm = m_dst_m(in_code, ra);
        if (de != 4'hF) mregs[de] = val_e;
        if (dm != 4'hF) mregs[dm] = val_m;
      end
    end
    #1;
    in_code = 4'h1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0);
    dbg_sel = 4'h0;
    model_reset();
    #12;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      checks++;
      if (dbg_val !== ((i == 4) ? 64'h100 : 64'd0)) begin
        errors++; $display("FAIL reset_reg%0d got %h want %h", i, dbg_val, (i == 4) ? 64'h100 : 64'd0);
      end
    end
  endtask

  task automatic test_irmovq_opq();
    drive(4'h3, 4'hF, 4'h2, 64'd23, 64'd0, 1'b1);
    tick();
    dbg_sel = 4'h2; #1;
    checks++;
    if (dbg_val !== 64'd23) begin errors++; $display("FAIL irmovq_r2 got %0d want 23", dbg_val); end
    drive(4'h6, 4'h2, 4'h2, 64'd46, 64'd0, 1'b0);
    #1;
    checks++;
    if (val_a !== exp_read(4'h2) || val_b !== exp_read(4'h2) || mregs[2] !== 64'd23) begin
      errors++; $display("FAIL opq_operands got a=%0d b=%0d want %0d", val_a, val_b, exp_read(4'h2));
    end
    tick();
    checks++;
    if (dbg_val !== 64'd46) begin errors++; $display("FAIL opq_r2 got %0d want 46", dbg_val); end
  endtask

  task automatic test_cmov();
    dbg_sel = 4'h3;
    drive(4'h2, 4'h1, 4'h3, 64'd117, 64'd0, 1'b0);
    tick();
    checks++;
    if (dbg_val !== 64'd0) begin errors++; $display("FAIL cmov_nottaken got %0d want 0", dbg_val); end
    drive(4'h2, 4'h1, 4'h3, 64'd117, 64'd0, 1'b1);
    #1;
    checks++;
    if (val_a !== exp_read(4'h1)) begin errors++; $display("FAIL cmov_vala got %h want %h", val_a, exp_read(4'h1)); end
    tick();
    checks++;
    if (dbg_val !== 64'd117) begin errors++; $display("FAIL cmov_taken got %0d want 117", dbg_val); end
  endtask

  task automatic test_popq_rsp();
    logic [63:0] want;
    dbg_sel = 4'h4;
    drive(4'hB, 4'h4, 4'hF, 64'h108, 64'h55, 1'b1);
    #1;
    want = exp_read(4'h4);
    checks++;
    if (val_a !== want || val_b !== want) begin
      errors++; $display("FAIL popq_operands got a=%h b=%h want %h", val_a, val_b, want);
    end
    tick();
    checks++;
    if (dbg_val !== 64'h55) begin errors++; $display("FAIL popq_rsp got %h want 55", dbg_val); end
  endtask

  task automatic test_bypass_read();
    logic [63:0] want;
    dbg_sel = 4'h2;
`ifdef REGFILE_BYPASS_EN
    want = 64'd91;
`else
    want = mregs[2];
`endif
    drive(4'h3, 4'hF, 4'h2, 64'd91, 64'd0, 1'b1);
    #1;
    checks++;
    if (dbg_val !== want) begin errors++; $display("FAIL bypass_dbg got %0d want %0d", dbg_val, want); end
    tick();
    checks++;
    if (dbg_val !== 64'd91) begin errors++; $display("FAIL bypass_commit got %0d want 91", dbg_val); end
  endtask

  task automatic test_random();
    logic [3:0] c;
    for (int n = 0; n < 300; n++) begin
      c = 4'($urandom_range(1, 15));
      drive(c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      dbg_sel = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (val_a !== exp_read(m_src_a(in_code, ra)) || val_b !== exp_read(m_src_b(in_code, rb)) ||
          dbg_val !== exp_read(dbg_sel) || halted !== mhalt) begin
        errors++;
        $display("FAIL random_%0d code=%h ra=%h rb=%h sel=%h got a=%h b=%h d=%h h=%0b want a=%h b=%h d=%h h=%0b",
                 n, in_code, ra, rb, dbg_sel, val_a, val_b, dbg_val, halted,
                 exp_read(m_src_a(in_code, ra)), exp_read(m_src_b(in_code, rb)), exp_read(dbg_sel), mhalt);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    drive(4'h0, 4'h1, 4'h2, 64'd5, 64'd6, 1'b1);
    tick();
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %0b want 1", halted); end
    dbg_sel = 4'h5;
    drive(4'h3, 4'hF, 4'h5, 64'd9, 64'd0, 1'b1);
    #1;
    checks++;
    if (dbg_val !== mregs[5]) begin errors++; $display("FAIL halt_nofwd got %h want %h", dbg_val, mregs[5]); end
    tick();
    checks++;
    if (dbg_val !== mregs[5] || halted !== 1'b1) begin
      errors++; $display("FAIL halt_nowrite got r5=%h h=%0b want %h 1", dbg_val, halted, mregs[5]);
    end
    drive(4'h6, 4'h1, 4'h3, 64'd1, 64'd0, 1'b0);
    #1;
    checks++;
    if (val_a !== mregs[1] || val_b !== mregs[3]) begin
      errors++; $display("FAIL halt_decode_live got a=%h b=%h want %h %h", val_a, val_b, mregs[1], mregs[3]);
    end
    drive(4'h3, 4'hF, 4'h6, 64'd77, 64'd0, 1'b1);
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL async_reset_halted got %0b want 0", halted); end
    tick();
    reset_n = 1'b1;
    dbg_sel = 4'h6;
    #1;
    checks++;
    if (dbg_val !== 64'd0) begin errors++; $display("FAIL reset_discard got %h want 0", dbg_val); end
    dbg_sel = 4'h4;
    #1;
    checks++;
    if (dbg_val !== 64'h100) begin errors++; $display("FAIL reset_rsp got %h want 100", dbg_val); end
  endtask

  initial begin
    test_reset();
    test_irmovq_opq();
    test_cmov();
    test_popq_rsp();
    test_bypass_read();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
